// File: rtl/uart_tx_arbiter_pkg.sv
// Shared FSM encoding and counter-width helper for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARB     = 3'd1,
      ST_LOAD    = 3'd2,
      ST_START   = 3'd3,
      ST_WAIT_HI = 3'd4,
      ST_WAIT_LO = 3'd5,
      ST_GAP     = 3'd6
   } arb_state_e;

   // Ceiling log2 that never returns less than one bit.
   function automatic int log2_ceil_min1(input int value);
      int w;
      w = $clog2(value);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first valid bit at or above ptr, wrapping.
module rr_priority_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      logic [IDX_W-1:0] cand;
      logic             take;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      cand   = '0;
      take   = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand         = IDX_W'((int'(ptr) + k) % N);
         take         = valid[cand] & ~any;
         onehot[cand] = onehot[cand] | take;
         idx          = take ? cand : idx;
         any          = any | take;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART Tx between NUM_REQ byte streams, round-robin per packet,
// sequencing the start/busy handshake with an optional post-packet idle gap.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int BITS         = 8,
   parameter int GAP_TICKS    = 0,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*BITS-1:0] req_data,
   input  logic [NUM_REQ-1:0]      req_last,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [BITS-1:0]         tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   input  logic                    baud_tick,
   output logic [NUM_REQ-1:0]      grant,
   output logic                    err_timeout
);

   localparam int PTR_W = log2_ceil_min1(NUM_REQ);
   localparam int TO_W  = log2_ceil_min1(BUSY_TIMEOUT + 1);
   localparam int GAP_W = log2_ceil_min1(GAP_TICKS + 1);

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

   arb_state_e           state_r, state_s;
   logic [PTR_W-1:0]     ptr_r, ptr_s;
   logic [NUM_REQ-1:0]   grant_r, grant_s;
   logic [PTR_W-1:0]     gidx_r, gidx_s;
   logic [BITS-1:0]      tx_data_r, tx_data_s;
   logic                 last_r, last_s;
   logic [NUM_REQ-1:0]   req_ready_r, req_ready_s;
   logic                 tx_start_r, tx_start_s;
   logic                 err_r, err_s;
   logic [TO_W-1:0]      to_cnt_r, to_cnt_s;
   logic [GAP_W-1:0]     gap_cnt_r, gap_cnt_s;
   logic                 byte_done_s;

   logic [NUM_REQ-1:0]   pick_grant_s;
   logic [PTR_W-1:0]     pick_idx_s;
   logic                 pick_any_s;
   logic [BITS-1:0]      data_arr_s [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr_s[gi] = req_data[gi*BITS +: BITS];
   end

   rr_priority_pick #(
      .N     (NUM_REQ),
      .IDX_W (PTR_W)
   ) u_pick (
      .valid  (req_valid),
      .ptr    (ptr_r),
      .onehot (pick_grant_s),
      .idx    (pick_idx_s),
      .any    (pick_any_s)
   );

   // Next-state and next-output logic; the grant is held until the last byte completes.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      grant_s     = grant_r;
      gidx_s      = gidx_r;
      tx_data_s   = tx_data_r;
      last_s      = last_r;
      req_ready_s = '0;
      tx_start_s  = 1'b0;
      err_s       = err_r;
      to_cnt_s    = to_cnt_r;
      gap_cnt_s   = gap_cnt_r;
      byte_done_s = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if ((|req_valid) && !tx_busy) state_s = ST_ARB;
            else                          state_s = ST_IDLE;
         end
         ST_ARB: begin
            if (pick_any_s) begin
               grant_s = pick_grant_s;
               gidx_s  = pick_idx_s;
               state_s = ST_LOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (req_valid[gidx_r]) begin
               tx_data_s   = data_arr_s[gidx_r];
               last_s      = req_last[gidx_r];
               req_ready_s = grant_r;
               state_s     = ST_START;
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_START: begin
            tx_start_s = 1'b1;
            to_cnt_s   = '0;
            state_s    = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            // A Tx that never acknowledges must not wedge the shared channel.
            if (tx_busy) begin
               state_s = ST_WAIT_LO;
            end else if (to_cnt_r == TO_LAST) begin
               err_s       = 1'b1;
               byte_done_s = 1'b1;
            end else begin
               to_cnt_s = to_cnt_r + 1'b1;
            end
         end
         ST_WAIT_LO: begin
            if (!tx_busy) byte_done_s = 1'b1;
            else          state_s     = ST_WAIT_LO;
         end
         ST_GAP: begin
            if (baud_tick) begin
               if (gap_cnt_r == GAP_LAST) state_s   = ST_IDLE;
               else                       gap_cnt_s = gap_cnt_r + 1'b1;
            end else begin
               state_s = ST_GAP;
            end
         end
         default: begin
            state_s = ST_IDLE;
            grant_s = '0;
         end
      endcase

      // The finishing requester drops to lowest priority for the next round.
      if (byte_done_s && last_r) begin
         grant_s   = '0;
         ptr_s     = (gidx_r == LAST_IDX) ? '0 : gidx_r + 1'b1;
         gap_cnt_s = '0;
         state_s   = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
      end else if (byte_done_s) begin
         state_s = ST_LOAD;
      end else begin
         ptr_s = ptr_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ptr_r       <= '0;
         grant_r     <= '0;
         gidx_r      <= '0;
         tx_data_r   <= '0;
         last_r      <= 1'b0;
         req_ready_r <= '0;
         tx_start_r  <= 1'b0;
         err_r       <= 1'b0;
         to_cnt_r    <= '0;
         gap_cnt_r   <= '0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         grant_r     <= grant_s;
         gidx_r      <= gidx_s;
         tx_data_r   <= tx_data_s;
         last_r      <= last_s;
         req_ready_r <= req_ready_s;
         tx_start_r  <= tx_start_s;
         err_r       <= err_s;
         to_cnt_r    <= to_cnt_s;
         gap_cnt_r   <= gap_cnt_s;
      end
   end

   assign req_ready   = req_ready_r;
   assign tx_data     = tx_data_r;
   assign tx_start    = tx_start_r;
   assign grant       = grant_r;
   assign err_timeout = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected (grant, byte) pairs, a monitor
// pops one on every tx_start; a simple Tx model and baud source drive the DUT.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int BITS         = 8;
   localparam int GAP_TICKS    = 2;
   localparam int BUSY_TIMEOUT = 16;
   localparam int BUSY_LEN     = 10;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NUM_REQ-1:0]      req_valid = '0;
   logic [NUM_REQ*BITS-1:0] req_data = '0;
   logic [NUM_REQ-1:0]      req_last = '0;
   logic [NUM_REQ-1:0]      req_ready;
   logic [BITS-1:0]         tx_data;
   logic                    tx_start;
   logic                    tx_busy = 1'b0;
   logic                    baud_tick = 1'b0;
   logic [NUM_REQ-1:0]      grant;
   logic                    err_timeout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [8:0]  rmem [NUM_REQ][64];
   int          rhead [NUM_REQ];
   int          rtail [NUM_REQ];
   logic [3:0]  stall = 4'b0000;
   logic        tx_never = 1'b0;
   logic [11:0] exp_q [$];
   int          ready_cnt [NUM_REQ];
   int          tick_total = 0;
   logic        rst_at_edge = 1'b0;

   uart_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .BITS         (BITS),
      .GAP_TICKS    (GAP_TICKS),
      .BUSY_TIMEOUT (BUSY_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .baud_tick   (baud_tick),
      .grant       (grant),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Queue a byte for requester r and its expected transmission (call in expected order).
   task automatic send(input int r, input logic [7:0] d, input logic last);
      logic [3:0] oh;
      oh = 4'b0001 << r;
      rmem[r][rtail[r]] = {last, d};
      rtail[r] = rtail[r] + 1;
      exp_q.push_back({oh, d});
   endtask

   // Requester driver: consume on req_ready, present next queued byte.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && rhead[i] < rtail[i]) rhead[i] = rhead[i] + 1;
            if (rhead[i] < rtail[i]) begin
               req_valid[i]            = ~stall[i];
               req_data[i*BITS +: BITS] = rmem[i][rhead[i]][7:0];
               req_last[i]             = rmem[i][rhead[i]][8];
            end else begin
               req_valid[i]            = 1'b0;
               req_data[i*BITS +: BITS] = 8'h00;
               req_last[i]             = 1'b0;
            end
         end
      end
   end

   // Tx model: Busy rises right after tx_start and stays high BUSY_LEN cycles.
   initial begin
      int bcnt;
      bcnt = 0;
      forever begin
         @(negedge clk);
         if (rst) bcnt = 0;
         else if (tx_start && !tx_never) bcnt = BUSY_LEN;
         else if (bcnt > 0) bcnt = bcnt - 1;
         tx_busy = (bcnt > 0);
      end
   end

   // Baud source: one tick every third cycle.
   initial begin
      int div;
      div = 0;
      forever begin
         @(negedge clk);
         div = (div == 2) ? 0 : div + 1;
         baud_tick = (div == 0);
         if (div == 0) tick_total = tick_total + 1;
      end
   end

   // Monitor / scoreboard.
   initial begin
      logic [11:0] e;
      logic [3:0]  prev_ready;
      logic [3:0]  prev_grant;
      logic        released;
      int          tick_mark;
      prev_ready = '0;
      prev_grant = '0;
      released   = 1'b0;
      tick_mark  = 0;
      forever begin
         @(posedge clk);
         #2;
         if (tx_start) begin
            if (exp_q.size() == 0) begin
               check("unexpected_tx_start", {24'h0, tx_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("tx_data", {24'h0, tx_data}, {24'h0, e[7:0]});
               check("grant_at_start", {28'h0, grant}, {28'h0, e[11:8]});
            end
         end
         if (req_ready != 4'b0000) begin
            check("ready_is_grant", {28'h0, req_ready}, {28'h0, grant});
            check("ready_not_back2back", {28'h0, prev_ready}, 32'h0);
            for (int i = 0; i < NUM_REQ; i++)
               if (req_ready[i]) ready_cnt[i] = ready_cnt[i] + 1;
         end
         if (rst_at_edge) begin
            released = 1'b0;
         end else if (prev_grant != 4'b0000 && grant == 4'b0000) begin
            released  = 1'b1;
            tick_mark = tick_total;
         end else if (released && grant != 4'b0000) begin
            check("gap_ticks_elapsed", {31'h0, (tick_total - tick_mark) >= GAP_TICKS}, 32'h1);
            released = 1'b0;
         end
         prev_ready = req_ready;
         prev_grant = grant;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || grant != 4'b0000 || tx_busy) && n < 3000) begin
         next_cycle();
         n++;
      end
      check({tag, "_drained"}, {31'h0, n < 3000}, 32'h1);
   endtask

   // Call right after send() on an idle arbiter: grant +2, ready +3, start +4 cycles.
   task automatic measure_latency(input string tag);
      int v, tg, tr, ts;
      v  = cyc;
      tg = -100;
      tr = -100;
      ts = -100;
      for (int k = 0; k < 12; k++) begin
         next_cycle();
         if (tg < 0 && grant != 4'b0000) tg = cyc;
         if (tr < 0 && req_ready != 4'b0000) tr = cyc;
         if (ts < 0 && tx_start) ts = cyc;
      end
      check({tag, "_grant_latency"}, tg - v, 2);
      check({tag, "_ready_latency"}, tr - v, 3);
      check({tag, "_start_latency"}, ts - v, 4);
   endtask

   task automatic wait_start(input string tag, output int t);
      int n;
      n = 0;
      t = -1;
      while (!tx_start && n < 200) begin
         next_cycle();
         n++;
      end
      if (tx_start) t = cyc;
      check({tag, "_start_seen"}, {31'h0, tx_start}, 32'h1);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      next_cycle();
      check("rst_grant", {28'h0, grant}, 32'h0);
      check("rst_tx_start", {31'h0, tx_start}, 32'h0);
      check("rst_req_ready", {28'h0, req_ready}, 32'h0);
      check("rst_err_timeout", {31'h0, err_timeout}, 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      int t0, te, bad, n;
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, te, bad, n;
      repeat (3) next_cycle();
      check("reset_tx_data", {24'h0, tx_data}, 32'h0);
      pulse_reset();
      next_cycle();

      // Single 3-byte packet from requester 0.
      send(0, 8'h11, 1'b0);
      send(0, 8'h22, 1'b0);
      send(0, 8'h33, 1'b1);
      measure_latency("single");
      wait_drain("single");
      check("single_ready_count", ready_cnt[0], 3);
      check("single_grant_released", {28'h0, grant}, 32'h0);

      // Contention from pointer 0: requester 0 packet, then requester 2.
      pulse_reset();
      next_cycle();
      send(0, 8'hA1, 1'b0);
      send(0, 8'hA2, 1'b1);
      send(2, 8'hC1, 1'b0);
      send(2, 8'hC2, 1'b1);
      wait_drain("contention");

      // Pointer now 3: single-byte packets from all four go 3,0,1,2.
      send(3, 8'h30, 1'b1);
      send(0, 8'h40, 1'b1);
      send(1, 8'h41, 1'b1);
      send(2, 8'h42, 1'b1);
      wait_drain("fairness");

      // Requester 1 stalls mid-packet while requester 0 waits.
      send(1, 8'hD1, 1'b0);
      send(1, 8'hD2, 1'b1);
      n = 0;
      while (req_ready[1] !== 1'b1 && n < 200) begin
         next_cycle();
         n++;
      end
      check("stall_first_ready", {31'h0, req_ready[1]}, 32'h1);
      stall[1] = 1'b1;
      send(0, 8'hE1, 1'b1);
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         next_cycle();
         if (grant != 4'b0010) bad++;
      end
      check("stall_grant_held_cycles_bad", bad, 0);
      stall[1] = 1'b0;
      wait_drain("stall");

      // Tx never raises Busy: sticky error 16 cycles after tx_start, then carry on.
      check("err_clear_before_timeout", {31'h0, err_timeout}, 32'h0);
      tx_never = 1'b1;
      send(0, 8'hF1, 1'b0);
      send(0, 8'hF2, 1'b1);
      wait_start("timeout", t0);
      n = 0;
      while (!err_timeout && n < 60) begin
         next_cycle();
         n++;
      end
      te = cyc;
      check("timeout_delay", te - t0, BUSY_TIMEOUT);
      wait_drain("timeout");
      check("err_sticky", {31'h0, err_timeout}, 32'h1);
      tx_never = 1'b0;

      // Reset while the character is on the line, then arbitration restarts from IDLE.
      send(2, 8'h5A, 1'b1);
      wait_start("midchar", t0);
      repeat (3) next_cycle();
      pulse_reset();
      next_cycle();
      send(1, 8'h77, 1'b1);
      measure_latency("after_reset");
      wait_drain("after_reset");
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit unit (Tx + baud generator) between NUM_REQ independent byte-stream requesters.
- Round-robin arbitration at packet granularity: a granted requester keeps the transmitter until the byte it marks "last" has been sent.
- Sequences the Tx handshake (start pulse, Busy rise, Busy fall) and optionally enforces an inter-packet idle gap counted in baud ticks.
- Sits between the emulator / host-side producers and the Tx instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BITS, 8, data bits per UART character.
- GAP_TICKS, 0, baud ticks of forced idle after each packet (0 = no gap).
- BUSY_TIMEOUT, 16, clk cycles to wait for tx_busy to rise after tx_start.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*BITS  byte of requester i at [i*BITS +: BITS].
- req_last  in  NUM_REQ  byte is the final byte of its packet.
- req_ready  out  NUM_REQ  one-hot pulse; byte accepted from that requester.
- tx_data  out  BITS  to Tx TxD_data.
- tx_start  out  1  to Tx TxD_start; single-cycle pulse.
- tx_busy  in  1  from Tx Busy.
- baud_tick  in  1  from Baud_Rate_Generator.
- grant  out  NUM_REQ  one-hot owner of the transmitter; 0 when none.
- err_timeout  out  1  sticky; tx_busy failed to rise in time.

Behaviour:
- Reset values:
  - req_ready=0, tx_data=0, tx_start=0, grant=0, err_timeout=0.
  - Round-robin pointer = 0; state = IDLE.
- States:
  - IDLE:
    - Enter ARB only if any req_valid=1 and tx_busy=0. Otherwise stay.
  - ARB:
    - Select the first valid requester searching from the pointer upward, wrapping modulo NUM_REQ. Set grant one-hot to it.
    - Go to LOAD. Cost: 1 cycle.
    - If the selected req_valid dropped, the choice is still made; LOAD waits.
  - LOAD:
    - If req_valid[g]=1: latch req_data[g] into tx_data, latch req_last[g] internally, pulse req_ready[g] for 1 cycle, go to START.
    - Otherwise hold (grant retained, packet lock).
  - START:
    - Assert tx_start=1 for exactly 1 cycle with tx_data stable. Clear the timeout counter. Go to WAIT_HI.
  - WAIT_HI:
    - On tx_busy=1: go to WAIT_LO.
    - Otherwise increment the counter. When it reaches BUSY_TIMEOUT: set err_timeout=1 and treat the byte as sent (continue as if WAIT_LO finished).
  - WAIT_LO:
    - On tx_busy=0: if the latched last=0, go to LOAD (same grant).
    - If last=1: clear grant, set pointer = g+1 mod NUM_REQ, go to GAP (or IDLE if GAP_TICKS=0).
  - GAP:
    - Count baud_tick pulses; after GAP_TICKS of them go to IDLE.
- Latency (idle transmitter, request waiting in IDLE):
  - grant asserted 2 cycles after req_valid is sampled.
  - req_ready 3 cycles after.
  - tx_start 4 cycles after.
- req_ready is asserted only in LOAD, only to the granted requester, never two cycles in a row.
- tx_data changes only in LOAD; it is held through the whole character.
- Simultaneous requests: lowest index at or above the pointer wins. Example: pointer=2 with valid=4'b1011 → grant requester 3.
- Fairness: a requester that just finished a packet is last in priority for the next arbitration. Starvation bound is NUM_REQ-1 packets.
- A requester may drop req_valid mid-packet. The arbiter waits indefinitely in LOAD; no timeout on requesters.
- err_timeout is cleared only by rst.
- tx_busy already high on entry to IDLE (external use) blocks arbitration until it falls.
- rst mid-character: all outputs and state return to reset values next cycle. The Tx instance is reset by the same rst.
- Counter widths:
  - $clog2(BUSY_TIMEOUT+1) for the timeout counter.
  - $clog2(GAP_TICKS+1), minimum 1, for the gap counter.
  - $clog2(NUM_REQ), minimum 1, for the pointer.

Decomposition:
- Shared package/macros.v:
  - State encodings IDLE..GAP as localparams.
  - Reuse of the existing LOG2_CEIL macro for counter widths.
- One natural sub-module: rr_priority_pick.
  - Combinational round-robin one-hot select from (valid vector, pointer).
  - Reusable by other arbiters.
- Everything else lives in the FSM.

Test Plan:
- Single packet: req 0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), Tx model holds Busy 10 cycles.
  - Expect three tx_start pulses with tx_data 0x11,0x22,0x33 in order.
  - Expect three req_ready[0] pulses; grant=0001 throughout, then 0.
- Contention: req 0 and req 2 each hold a 2-byte packet at once, pointer=0.
  - Expect req 0's packet fully sent before any req 2 byte; then grant=0100.
  - Pointer ends at 3.
- Fairness wrap: pointer=3, valid=1111 with single-byte packets.
  - Expect grant order 3,0,1,2.
- Stall mid-packet: req 1 drops valid after its first byte for 50 cycles while req 0 is valid.
  - Expect grant to stay 0010, no req 0 bytes sent.
  - Resumes with req 1's second byte.
- Busy timeout: Tx model never raises Busy, BUSY_TIMEOUT=16.
  - Expect err_timeout=1 exactly 16 cycles after tx_start; arbiter continues to the next byte.
- Reset mid-character plus gap: GAP_TICKS=2.
  - After a packet, expect no grant until 2 baud_tick pulses have elapsed.
  - Asserting rst during WAIT_LO returns grant=0, tx_start=0, and the FSM to IDLE on the next cycle.
